// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the RV32I instruction-fetch stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
//------------------------------------------------------------------------------
// fetch_skid_buf : two-entry main/skid buffer for fetched instructions
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t main_entry,
  output logic         main_valid,
  output logic         skid_valid
);

  fetch_entry_t main_q, main_d;
  fetch_entry_t skid_q, skid_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      // Retire main first so an incoming push sees the freed slot.
      if (pop) begin
        main_valid_d = skid_valid_q;
        skid_valid_d = 1'b0;
        if (skid_valid_q) begin
          main_d = skid_q;
        end
      end
      if (push) begin
        if (!main_valid_d) begin
          main_d       = push_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = push_entry;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign main_entry = main_q;
  assign main_valid = main_valid_q;
  assign skid_valid = skid_valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : RV32I IF stage - PC, imem req/ack handshake, redirect, IF/ID feed
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PC_plus_4F,
  output logic                  ValidF
);

  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic                  live_q;

  logic                  main_valid, skid_valid;
  fetch_entry_t          main_entry, push_entry;
  logic                  ack_taken, consume, push;
  logic [DATA_WIDTH-1:0] pc_word, target_word;

  assign pc_word     = pc_q & WORD_MASK;
  assign target_word = PCTargetE & WORD_MASK;
  assign ack_taken   = imem_req & imem_ack;
  assign consume     = main_valid & ~StallF & ~PCSrcE;
  assign push        = (state_q == FETCH) & ack_taken & ~PCSrcE;

  // State register; live_q keeps the request low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC & WORD_MASK;
      drop_addr_q <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      live_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (PCSrcE && imem_req && !imem_ack) state_d = DROP;
      DROP:    if (imem_ack) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_word;
    if (live_q) begin
      case (state_q)
        FETCH: begin
          imem_req  = ~skid_valid;
          imem_addr = pc_word;
        end
        DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr_q;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = pc_word;
        end
      endcase
    end
  end

  // The abandoned address must stay on the bus while PC already points at the target.
  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if (PCSrcE) begin
      pc_d = target_word;
      if (state_q == FETCH) begin
        drop_addr_d = imem_addr;
      end
    end else if (push) begin
      pc_d = pc_word + DATA_WIDTH'(4);
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.instr     = imem_rdata;
    push_entry.pc        = pc_word;
    push_entry.pc_plus_4 = pc_word + DATA_WIDTH'(4);
  end

  fetch_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (PCSrcE),
    .push       (push),
    .push_entry (push_entry),
    .pop        (consume),
    .main_entry (main_entry),
    .main_valid (main_valid),
    .skid_valid (skid_valid)
  );

  assign ValidF     = main_valid;
  assign InstrF     = main_valid ? main_entry.instr : NOP_INSTR;
  assign PCF        = main_entry.pc;
  assign PC_plus_4F = main_entry.pc_plus_4;

endmodule

`default_nettype wire
